// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the MEM stage and a clk_stall-handshaked data memory.
// Optional feature macro: STORE_FWD_EN (word loads answered from a matching queued word store).
module data_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall,
  output logic [1:0]  dbg_state
);

  // Handshakes: a cpu request is held until a cycle with cpu_stall low, which completes it
  // at the next edge; a memory request is a one-cycle pulse, then mem_stall high = busy, low = done.

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0]      fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [3:0]       fifo_mask [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic        full, empty, push, pop;
  logic        op_load;
  logic        load_done;
  logic        load_issue, load_complete;
  logic        fwd_take;
  logic [31:0] fwd_data;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // With both request lines high the cycle is a load and the store is dropped.
  assign push = cpu_memwrite && !cpu_memread && !full;
  assign pop  = (state == WAIT_DONE) && !mem_stall && !op_load;

  assign load_complete = (state == WAIT_DONE) && !mem_stall && op_load;
  assign load_issue    = empty && cpu_memread && !load_done && !fwd_take;

  assign cpu_stall = (cpu_memwrite && !cpu_memread && full) || (cpu_memread && !load_done);
  assign dbg_state = state;

`ifdef STORE_FWD_EN
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching word store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((CW'(k) < count) && (fifo_mask[fwd_idx][2:0] == 3'b111) &&
          (fifo_addr[fwd_idx][31:2] == cpu_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[fwd_idx];
      end
    end
  end

  assign fwd_take = cpu_memread && !load_done && (cpu_sign_mask[2:0] == 3'b111) && fwd_hit;
`else
  assign fwd_take = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_write_data;
      fifo_mask[wr_ptr] <= cpu_sign_mask;
    end
  end

  always_comb begin
    state_next   = state;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty || load_issue) state_next = ISSUE;
      end
      ISSUE: begin
        mem_memwrite = !op_load;
        mem_memread  = op_load;
        state_next   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mem_stall) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!mem_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      op_load        <= 1'b0;
      load_done      <= 1'b0;
      cpu_read_data  <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // Memory-side fields are captured once on entry to ISSUE and held until the next issue.
      if ((state == IDLE) && (state_next == ISSUE)) begin
        op_load <= empty;
        if (empty) begin
          mem_addr       <= cpu_addr;
          mem_write_data <= '0;
          mem_sign_mask  <= cpu_sign_mask;
        end else begin
          mem_addr       <= fifo_addr[rd_ptr];
          mem_write_data <= fifo_data[rd_ptr];
          mem_sign_mask  <= fifo_mask[rd_ptr];
        end
      end

      load_done <= 1'b0;
      if (load_complete) begin
        load_done     <= 1'b1;
        cpu_read_data <= mem_read_data;
      end else if (fwd_take) begin
        load_done     <= 1'b1;
        cpu_read_data <= fwd_data;
      end
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer: vector tables, hand sequences for multi-cycle corners,
// a write scoreboard and a small responding data memory.
`timescale 1ns/1ps
module tb_data_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_write_data = '0;
  logic        cpu_memwrite = 1'b0;
  logic        cpu_memread = 1'b0;
  logic [3:0]  cpu_sign_mask = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_stall = 1'b0;
  logic [1:0]  dbg_state;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  data_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_stall(mem_stall), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // memory responder: little-endian words, busy for mem_lat cycles after a request
  logic [31:0] mem_words [64];
  int          mem_lat = 1;
  int          busy_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] w;
    logic [31:0] r;
    w = mem_words[a[7:2]];
    case (m[2:0])
      3'b001: begin
        r = (w >> {a[1:0], 3'b000}) & 32'h0000_00FF;
        if (m[3] && r[7]) r = r | 32'hFFFF_FF00;
      end
      3'b011: begin
        r = (w >> {a[1], 4'b0000}) & 32'h0000_FFFF;
        if (m[3] && r[15]) r = r | 32'hFFFF_0000;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_stall) begin
      if (busy_cnt == 0) mem_stall <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
    if (mem_memwrite) begin
      case (mem_sign_mask[2:0])
        3'b001:  mem_words[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] = mem_write_data[7:0];
        3'b011:  mem_words[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] = mem_write_data[15:0];
        default: mem_words[mem_addr[7:2]] = mem_write_data;
      endcase
      mem_stall <= 1'b1;
      busy_cnt  <= mem_lat - 1;
    end else if (mem_memread) begin
      mem_read_data <= mem_rd(mem_addr, mem_sign_mask);
      mem_stall     <= 1'b1;
      busy_cnt      <= mem_lat - 1;
    end
  end

  // scoreboard: expected write stream {addr, data, mask}
  logic [67:0] exp_q[$];
  int          writes_seen = 0;
  int          reads_seen = 0;
  int          peak = 0;
  bit          chk_wr_next = 0;
  bit          chk_rd_next = 0;
  bit          inflight = 0;
  logic [31:0] req_addr, req_data;

  always @(negedge clk) begin
    logic [67:0] e;
    if (chk_wr_next) begin check("wr_pulse_width", 32'(mem_memwrite), 0); chk_wr_next = 0; end
    if (chk_rd_next) begin check("rd_pulse_width", 32'(mem_memread), 0); chk_rd_next = 0; end
    if (reset) inflight = 0;
    else if (inflight) begin
      if (dbg_state == 2'd0) inflight = 0;
      else begin
        check("hold_addr", mem_addr, req_addr);
        check("hold_data", mem_write_data, req_data);
      end
    end
    if (!reset && int'(dut.count) > peak) peak = int'(dut.count);
    if (mem_memwrite) begin
      writes_seen++;
      check("wr_mem_idle", 32'(mem_stall), 0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("wr_addr", mem_addr, e[67:36]);
      check("wr_data", mem_write_data, e[35:4]);
      check("wr_mask", 32'(mem_sign_mask), 32'(e[3:0]));
      chk_wr_next = 1;
      inflight = 1; req_addr = mem_addr; req_data = mem_write_data;
    end
    if (mem_memread) begin
      reads_seen++;
      check("rd_mem_idle", 32'(mem_stall), 0);
      check("rd_fifo_empty", 32'(dut.count), 0);
      check("rd_addr", mem_addr, cpu_addr);
      check("rd_mask", 32'(mem_sign_mask), 32'(cpu_sign_mask));
      chk_rd_next = 1;
      inflight = 1; req_addr = mem_addr; req_data = mem_write_data;
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int sc);
    cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m; cpu_memwrite = 1'b1;
    exp_q.push_back({a, d, m});
    sc = 0;
    #1;
    while (cpu_stall && sc < 300) begin @(negedge clk); #1; sc++; end
    @(negedge clk);
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                         output logic [31:0] rd, output int sc);
    cpu_addr = a; cpu_sign_mask = m; cpu_memread = 1'b1;
    sc = 0;
    #1;
    while (cpu_stall && sc < 300) begin @(negedge clk); #1; sc++; end
    rd = cpu_read_data;
    @(negedge clk);
    cpu_memread = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dut.count != 0 || dbg_state != 2'd0 || mem_stall) && n < 300) begin
      @(negedge clk); n++;
    end
    check("drained_count", 32'(dut.count), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          exp_stall;
  } st_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] exp_data;
    int          exp_stall;
  } ld_vec_t;

  st_vec_t fill_tbl[5];
  ld_vec_t ld_tbl[7];

  initial begin
    int sc;
    int w0, r0;
    logic [31:0] rd;

    fill_tbl[0] = '{32'h4000, 32'hA000_0000, 4'b0111, 0};
    fill_tbl[1] = '{32'h4004, 32'hA000_0001, 4'b0111, 0};
    fill_tbl[2] = '{32'h4008, 32'hA000_0002, 4'b0111, 0};
    fill_tbl[3] = '{32'h400C, 32'hA000_0003, 4'b0111, 0};
    fill_tbl[4] = '{32'h4010, 32'hA000_0004, 4'b0111, 1};

    ld_tbl[0] = '{32'h400C, 4'b0111, 32'h8765_C3A5, 4};
    ld_tbl[1] = '{32'h400C, 4'b1011, 32'hFFFF_C3A5, 4};
    ld_tbl[2] = '{32'h400E, 4'b0011, 32'h0000_8765, 4};
    ld_tbl[3] = '{32'h400E, 4'b1011, 32'hFFFF_8765, 4};
    ld_tbl[4] = '{32'h400D, 4'b1001, 32'hFFFF_FFC3, 4};
    ld_tbl[5] = '{32'h400F, 4'b0001, 32'h0000_0087, 4};
    ld_tbl[6] = '{32'h400C, 4'b1001, 32'hFFFF_FFA5, 4};

    // reset state, with a load request present during reset
    @(negedge clk);
    cpu_memread = 1'b1;
    #1;
    check("rst_stall_load", 32'(cpu_stall), 1);
    cpu_memread = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_count", 32'(dut.count), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_mem_mask", 32'(mem_sign_mask), 0);
    check("rst_mem_wr", 32'(mem_memwrite), 0);
    check("rst_mem_rd", 32'(mem_memread), 0);
    check("rst_rdata", cpu_read_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // single store
    w0 = writes_seen;
    do_store(32'h4004, 32'hDEAD_BEEF, 4'b0111, sc);
    check("single_stall", 32'(sc), 0);
    wait_idle();
    check("single_writes", 32'(writes_seen - w0), 1);

    // fill: fifth store waits for the first pop
    peak = 0;
    w0 = writes_seen;
    for (int i = 0; i < 5; i++) begin
      do_store(fill_tbl[i].addr, fill_tbl[i].data, fill_tbl[i].mask, sc);
      check($sformatf("fill_stall_%0d", i), 32'(sc), 32'(fill_tbl[i].exp_stall));
    end
    wait_idle();
    check("fill_writes", 32'(writes_seen - w0), 5);
    check("fill_peak", 32'(peak), 4);

    // load after two stores: read only after both drain, byte sign-extended
    r0 = reads_seen;
    do_store(32'h4000, 32'h0000_0080, 4'b0111, sc);
    do_store(32'h4004, 32'h0000_0055, 4'b0111, sc);
    do_load(32'h4000, 4'b1001, rd, sc);
    check("ld_after_st_data", rd, 32'hFFFF_FF80);
    check("ld_after_st_stall", 32'(sc), 11);
    check("ld_after_st_reads", 32'(reads_seen - r0), 1);
    repeat (3) @(negedge clk);
    check("ld_rdata_hold", cpu_read_data, 32'hFFFF_FF80);

    // load size/sign table on an empty FIFO
    do_store(32'h400C, 32'h8765_C3A5, 4'b0111, sc);
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      do_load(ld_tbl[i].addr, ld_tbl[i].mask, rd, sc);
      check($sformatf("ld_tbl_data_%0d", i), rd, ld_tbl[i].exp_data);
      check($sformatf("ld_tbl_stall_%0d", i), 32'(sc), 32'(ld_tbl[i].exp_stall));
    end

    // both request lines high: load wins, store dropped
    w0 = writes_seen;
    cpu_memwrite = 1'b1;
    cpu_write_data = 32'hBAD0_BAD0;
    do_load(32'h400C, 4'b0111, rd, sc);
    cpu_memwrite = 1'b0;
    check("both_data", rd, 32'h8765_C3A5);
    check("both_stall", 32'(sc), 4);
    repeat (6) @(negedge clk);
    check("both_no_write", 32'(writes_seen - w0), 0);
    check("both_count", 32'(dut.count), 0);

    // word load right behind a word store to the same word
    r0 = reads_seen;
    do_store(32'h4008, 32'h1234_5678, 4'b0111, sc);
    do_load(32'h4008, 4'b0111, rd, sc);
    check("fwd_data", rd, 32'h1234_5678);
    check("fwd_stall", 32'(sc), FWD ? 1 : 8);
    wait_idle();
    check("fwd_reads", 32'(reads_seen - r0), FWD ? 0 : 1);

    // two queued stores to one word: youngest value is returned
    r0 = reads_seen;
    do_store(32'h4008, 32'h1111_1111, 4'b0111, sc);
    do_store(32'h4008, 32'h2222_2222, 4'b0111, sc);
    do_load(32'h4008, 4'b0111, rd, sc);
    check("young_data", rd, 32'h2222_2222);
    check("young_stall", 32'(sc), FWD ? 1 : 11);
    wait_idle();
    check("young_reads", 32'(reads_seen - r0), FWD ? 0 : 1);

    // byte load against a queued word store always drains
    r0 = reads_seen;
    do_store(32'h4008, 32'h0000_00F1, 4'b0111, sc);
    do_load(32'h4008, 4'b0001, rd, sc);
    check("nonword_data", rd, 32'h0000_00F1);
    check("nonword_stall", 32'(sc), 8);
    wait_idle();
    check("nonword_reads", 32'(reads_seen - r0), 1);

    // reset while waiting for the memory with three entries queued
    for (int i = 0; i < 3; i++) do_store(32'h4030 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b0111, sc);
    for (int n = 0; n < 50 && dbg_state != 2'd2; n++) @(negedge clk);
    check("mid_pre_state", 32'(dbg_state), 2);
    check("mid_pre_count", 32'(dut.count), 3);
    #1 reset = 1'b1;
    #1;
    check("mid_count", 32'(dut.count), 0);
    check("mid_state", 32'(dbg_state), 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_mem_wdata", mem_write_data, 0);
    check("mid_mem_mask", 32'(mem_sign_mask), 0);
    check("mid_mem_wr", 32'(mem_memwrite), 0);
    check("mid_mem_rd", 32'(mem_memread), 0);
    check("mid_rdata", cpu_read_data, 0);
    check("mid_stall", 32'(cpu_stall), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    w0 = writes_seen;
    r0 = reads_seen;
    repeat (20) @(negedge clk);
    check("mid_no_writes", 32'(writes_seen - w0), 0);
    check("mid_no_reads", 32'(reads_seen - r0), 0);

    // pointer wrap: ten stores in groups of three, slower memory
    mem_lat = 3;
    peak = 0;
    w0 = writes_seen;
    for (int i = 0; i < 10; i++) begin
      do_store(32'h4040 + 32'(4 * i), 32'h5A00_0000 + 32'(i), 4'b0111, sc);
      check($sformatf("wrap_stall_%0d", i), 32'(sc), 0);
      if (i % 3 == 2 || i == 9) wait_idle();
    end
    check("wrap_writes", 32'(writes_seen - w0), 10);
    check("wrap_peak", 32'(peak), 3);
    check("wrap_wr_ptr", 32'(dut.wr_ptr), 2);
    check("wrap_rd_ptr", 32'(dut.rd_ptr), 2);
    mem_lat = 1;

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
- Posted-write buffer between the pipeline MEM stage and the data memory, which uses a one-cycle request and a clk_stall handshake.
- Stores are queued in a FIFO and drained to memory in the background, so the pipeline stalls on a store only when the FIFO is full.
- A load stalls the pipeline until the FIFO has drained and the memory read has completed. This guarantees program order.

Parameters:
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  byte address from the MEM stage.
- cpu_write_data  in  32  store data.
- cpu_memwrite  in  1  store request; held while cpu_stall is high.
- cpu_memread  in  1  load request; held while cpu_stall is high.
- cpu_sign_mask  in  4  bit 3 is the sign-extend flag; bits 2:0 are 001 for byte, 011 for halfword, 111 for word.
- cpu_read_data  out  32  load result.
- cpu_stall  out  1  combinational; freezes the pipeline.
- mem_addr  out  32  address to data memory.
- mem_write_data  out  32  store data to memory.
- mem_memwrite  out  1  one-cycle write request pulse.
- mem_memread  out  1  one-cycle read request pulse.
- mem_sign_mask  out  4  size and sign for the request.
- mem_read_data  in  32  memory load result; valid when mem_stall falls after a read.
- mem_stall  in  1  memory busy; rises the cycle after a request and falls when the access completes.

Behaviour:
- FIFO entry contents: addr[31:0], data[31:0], sign_mask[3:0].
- Pointers: wr_ptr and rd_ptr, plus count[PTR_W:0].
- Full is count==DEPTH; empty is count==0.

Store accept:
- Accepted when cpu_memwrite=1 && !full && cpu_memread=0.
- Enqueued at the edge; cpu_stall stays 0.
- If full, cpu_stall=1 until the cycle after a pop frees a slot.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.

Drain FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if !empty, or a load is pending with empty FIFO, go to ISSUE. Stores have priority over the load.
- ISSUE (1 cycle):
  - Drive mem_* from the FIFO head, or from the cpu_* load fields.
  - Pulse mem_memwrite or mem_memread for exactly this cycle.
  - Go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_stall=1, then go to WAIT_DONE.
- WAIT_DONE: wait for mem_stall=0, then return to IDLE.
  - Store: pop the head (rd_ptr+1, count-1).
  - Load: latch mem_read_data into cpu_read_data and set load_done for one cycle.
- Minimum store drain is 4 cycles per entry.

Memory-side outputs:
- mem_addr, mem_write_data and mem_sign_mask are registered.
- They are held stable from ISSUE through WAIT_DONE.

Load rule:
- cpu_stall = (cpu_memwrite && full) || (cpu_memread && !load_done).
- cpu_read_data is valid in the cycle load_done=1, which is also the cycle cpu_stall drops.
- It holds its value until the next load completes.
- A load is never issued while any store is queued, including stores accepted in the same cycle.

MMIO:
- A store to 0x2000 is queued like any other store; no special path.

Reset (asynchronous, mid-operation included):
- FIFO is emptied: pointers=0, count=0.
- FSM goes to IDLE and load_done=0.
- All mem_* outputs=0; cpu_read_data=0.
- cpu_stall follows its equation, so it is 0 when no request is present.
- In-flight memory operations are abandoned; the memory recovers on its own.

Illegal input:
- cpu_memread and cpu_memwrite both high: treated as a load; the store is ignored.

Optional Feature:
STORE_FWD_EN:
- When defined, a word load (sign_mask[2:0]=111) whose word address (addr[31:2]) matches any queued word store is answered from the youngest match. No drain occurs.
- The answer is returned the cycle after presentation: one stall cycle, then load_done.
- Non-word loads, or matches against byte or halfword stores, still drain.
- Undefined: every load drains first.

Test Plan:
- Single store: reset, then store addr=0x4004, data=0xDEADBEEF, mask=0111 -> cpu_stall stays 0; one mem_memwrite pulse with those values; count returns to 0 after mem_stall falls.
- Fill: 5 back-to-back stores to 0x4000..0x4010 with DEPTH=4 -> 5th store stalls until first pop; memory sees all 5 in order, each pulse exactly 1 cycle.
- Load after stores: 2 stores, then load 0x4000 mask=1001 with memory byte 0x80 -> mem_memread only after 2nd store completes; cpu_read_data=0xFFFFFF80.
- Wrap: 10 stores in groups of 3 with drains between -> pointers wrap, data order preserved, count never exceeds 4.
- Reset mid-drain: assert reset during WAIT_BUSY with 3 entries queued -> count=0, all mem_* outputs 0 immediately, no further mem pulses.
- STORE_FWD_EN: store 0x4008=0x12345678, then word load 0x4008 -> cpu_read_data=0x12345678 after 1 stall cycle, no mem_memread; with the macro undefined -> drain, then read.
